// File: rtl/adsr_32_if.sv
// Voice-control bundle between the note/parameter source and the ADSR envelope generator.
interface adsr_32_if;
    logic        gate;
    logic [13:0] attack;
    logic [13:0] decay;
    logic [31:0] sustain;
    logic [13:0] rel;
    logic [31:0] env;
    logic [2:0]  state;

    modport master (
        output gate, attack, decay, sustain, rel,
        input  env, state
    );

    modport slave (
        input  gate, attack, decay, sustain, rel,
        output env, state
    );
endinterface

// File: rtl/adsr_32.sv
// 32-bit linear ADSR envelope generator for one synth voice.
// Optional step prescaler enabled by defining ADSR_PRESCALE_EN (tick every 2^PRESCALE_W clocks).
module adsr_32 #(
    parameter int PRESCALE_W = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    adsr_32_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_e;

`ifdef ADSR_PRESCALE_EN
    localparam bit PRESCALE_ON = 1'b1;
`else
    localparam bit PRESCALE_ON = 1'b0;
`endif

    state_e                 state_q, state_d;
    logic [31:0]            env_q, env_d;
    logic [PRESCALE_W-1:0]  presc_q;
    logic                   tick;

    logic [32:0] sum_ext;
    logic [32:0] diff_ext;
    logic        atk_hit;
    logic        dec_hit;
    logic        rel_hit;

    // With the prescaler disabled the counter has no consumer and is trimmed away.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
        end
    end

    assign tick = PRESCALE_ON ? (&presc_q) : 1'b1;

    // 33-bit arithmetic: bit 32 flags overflow of the sum and underflow of the difference.
    assign sum_ext  = {1'b0, env_q} + {19'b0, bus.attack};
    assign diff_ext = {1'b0, env_q} - {19'b0, bus.decay};

    assign atk_hit = (bus.attack == 14'd0) || (sum_ext >= 33'h0_FFFF_FFFF);
    assign dec_hit = (bus.decay == 14'd0) || (env_q <= bus.sustain) ||
                     diff_ext[32] || (diff_ext[31:0] <= bus.sustain);
    assign rel_hit = (bus.rel == 14'd0) || (env_q <= {18'b0, bus.rel});

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.gate) begin
                    state_d = ST_ATTACK;
                end
            end
            ST_ATTACK: begin
                if (!bus.gate) begin
                    state_d = ST_RELEASE;
                end else if (tick) begin
                    if (atk_hit) begin
                        env_d   = 32'hFFFF_FFFF;
                        state_d = ST_DECAY;
                    end else begin
                        env_d = sum_ext[31:0];
                    end
                end
            end
            ST_DECAY: begin
                if (!bus.gate) begin
                    state_d = ST_RELEASE;
                end else if (tick) begin
                    if (dec_hit) begin
                        env_d   = bus.sustain;
                        state_d = ST_SUSTAIN;
                    end else begin
                        env_d = diff_ext[31:0];
                    end
                end
            end
            ST_SUSTAIN: begin
                if (!bus.gate) begin
                    state_d = ST_RELEASE;
                end else begin
                    env_d = bus.sustain;
                end
            end
            ST_RELEASE: begin
                // Retrigger keeps the current level so a legato note does not click.
                if (bus.gate) begin
                    state_d = ST_ATTACK;
                end else if (tick) begin
                    if (rel_hit) begin
                        env_d   = 32'd0;
                        state_d = ST_IDLE;
                    end else begin
                        env_d = env_q - {18'b0, bus.rel};
                    end
                end
            end
            default: begin
                env_d   = 32'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            env_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
        end
    end

    assign bus.env   = env_q;
    assign bus.state = state_q;
endmodule

// File: tb/tb_adsr_32.sv
// Self-checking bench for adsr_32: directed envelope scenarios plus randomized gate/parameter
// traffic, every clock compared against an arithmetic reference model of the envelope rules.
module tb_adsr_32;
`ifdef ADSR_PRESCALE_EN
    localparam int TICK_DIV = 16;
`else
    localparam int TICK_DIV = 1;
`endif
    localparam longint ENV_MAX = 64'd4294967295;

    logic clk;
    logic rst_n;
    adsr_32_if bus ();

    adsr_32 #(.PRESCALE_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase 0..4 as IDLE/ATTACK/DECAY/SUSTAIN/RELEASE, level as a plain integer.
    longint m_env   = 0;
    int     m_ph    = 0;
    int     m_cnt   = 0;
    bit     m_tick  = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_edge();
        longint a, d, r, s;
        a = longint'(bus.attack);
        d = longint'(bus.decay);
        r = longint'(bus.rel);
        s = longint'(bus.sustain);
        if (!rst_n) begin
            m_env  = 0;
            m_ph   = 0;
            m_cnt  = 0;
            m_tick = 1'b0;
            return;
        end
        m_tick = (TICK_DIV == 1) || (m_cnt == TICK_DIV - 1);
        m_cnt  = (m_cnt + 1) % 16;
        case (m_ph)
            0: if (bus.gate) m_ph = 1;
            1: begin
                if (!bus.gate) m_ph = 4;
                else if (m_tick) begin
                    if (a == 0 || m_env + a >= ENV_MAX) begin m_env = ENV_MAX; m_ph = 2; end
                    else m_env = m_env + a;
                end
            end
            2: begin
                if (!bus.gate) m_ph = 4;
                else if (m_tick) begin
                    if (d == 0 || m_env <= s || m_env - d <= s) begin m_env = s; m_ph = 3; end
                    else m_env = m_env - d;
                end
            end
            3: begin
                if (!bus.gate) m_ph = 4;
                else m_env = s;
            end
            default: begin
                if (bus.gate) m_ph = 1;
                else if (m_tick) begin
                    if (r == 0 || m_env <= r) begin m_env = 0; m_ph = 0; end
                    else m_env = m_env - r;
                end
            end
        endcase
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_edge();
        #1;
        check("env", 64'(bus.env), 64'(m_env));
        check("state", 64'(bus.state), 64'(m_ph));
    endtask

    task automatic tick_steps(input int n);
        int got;
        int guard;
        got = 0;
        guard = 0;
        while (got < n && guard < n * TICK_DIV + TICK_DIV + 2) begin
            clk_step();
            if (m_tick && rst_n) got++;
            guard++;
        end
        if (got < n) check("tick_timeout", 64'(got), 64'(n));
    endtask

    initial begin
        longint e0;
        rst_n       = 1'b0;
        bus.gate    = 1'b1;
        bus.attack  = 14'd0;
        bus.decay   = 14'd0;
        bus.sustain = 32'h8000_0000;
        bus.rel     = 14'd0;

        // Reset held with gate high
        for (int i = 0; i < 3; i++) begin
            clk_step();
            check("rst_env", 64'(bus.env), 64'd0);
            check("rst_state", 64'(bus.state), 64'd0);
        end
        rst_n = 1'b1;
        clk_step();
        check("rst_release_state", 64'(bus.state), 64'd1);
        $display("test reset: done");

        // Instant envelope
        rst_n = 1'b0;
        bus.gate = 1'b0;
        clk_step();
        rst_n = 1'b1;
        bus.gate = 1'b1;
        clk_step();
        check("inst_e1_state", 64'(bus.state), 64'd1);
        tick_steps(1);
        check("inst_e2_env", 64'(bus.env), 64'hFFFF_FFFF);
        check("inst_e2_state", 64'(bus.state), 64'd2);
        tick_steps(1);
        check("inst_e3_env", 64'(bus.env), 64'h8000_0000);
        check("inst_e3_state", 64'(bus.state), 64'd3);
        $display("test instant envelope: done");

        // Attack saturation boundary, entered legato from a preset sustain level
        bus.attack  = 14'd16383;
        bus.sustain = 32'(64'd4294967280 - 64'd100 * 64'd16383);
        clk_step();
        bus.gate = 1'b0;
        clk_step();
        bus.gate = 1'b1;
        clk_step();
        check("atk_start_state", 64'(bus.state), 64'd1);
        tick_steps(100);
        check("atk_last_env", 64'(bus.env), 64'd4294967280);
        check("atk_last_state", 64'(bus.state), 64'd1);
        tick_steps(1);
        check("atk_sat_env", 64'(bus.env), 64'hFFFF_FFFF);
        check("atk_sat_state", 64'(bus.state), 64'd2);
        $display("test attack timing: done");

        // Release floor boundary
        bus.decay   = 14'd0;
        bus.sustain = 32'(64'd8 + 64'd200 * 64'd16383);
        tick_steps(1);
        check("rel_sus_state", 64'(bus.state), 64'd3);
        bus.gate = 1'b0;
        bus.rel  = 14'd16383;
        clk_step();
        check("rel_start_env", 64'(bus.env), 64'd8 + 64'd200 * 64'd16383);
        tick_steps(200);
        check("rel_last_env", 64'(bus.env), 64'd8);
        check("rel_last_state", 64'(bus.state), 64'd4);
        tick_steps(1);
        check("rel_end_env", 64'(bus.env), 64'd0);
        check("rel_end_state", 64'(bus.state), 64'd0);
        $display("test release timing: done");

        // Mid-phase gate changes
        bus.attack  = 14'd0;
        bus.sustain = 32'h1233_6000;
        bus.gate    = 1'b1;
        clk_step();
        tick_steps(2);
        bus.gate = 1'b0;
        clk_step();
        bus.attack = 14'h1000;
        bus.gate   = 1'b1;
        clk_step();
        tick_steps(10);
        check("mid_atk_env", 64'(bus.env), 64'h1234_0000);
        bus.gate = 1'b0;
        bus.rel  = 14'h100;
        clk_step();
        check("mid_rel_state", 64'(bus.state), 64'd4);
        check("mid_rel_env", 64'(bus.env), 64'h1234_0000);
        tick_steps(5);
        bus.gate = 1'b1;
        clk_step();
        check("retrig_state", 64'(bus.state), 64'd1);
        check("retrig_env", 64'(bus.env), 64'h1233_FB00);
        bus.attack  = 14'd0;
        bus.decay   = 14'd0;
        bus.sustain = 32'h8000_0000;
        tick_steps(2);
        check("sus_old_env", 64'(bus.env), 64'h8000_0000);
        bus.sustain = 32'h4000_0000;
        clk_step();
        check("sus_new_env", 64'(bus.env), 64'h4000_0000);
        check("sus_new_state", 64'(bus.state), 64'd3);
        $display("test mid-phase gate changes: done");

        // Step rate: attack=100 over 32 clocks
        bus.gate = 1'b0;
        bus.rel  = 14'd0;
        clk_step();
        tick_steps(1);
        bus.gate   = 1'b1;
        bus.attack = 14'd100;
        clk_step();
        e0 = longint'(bus.env);
        for (int i = 0; i < 32; i++) clk_step();
        check("rate_delta", 64'(longint'(bus.env) - e0), 64'(3200 / TICK_DIV));
        $display("test step rate: done");

        // Randomized traffic
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 49) == 0) bus.gate = ~bus.gate;
            if ($urandom_range(0, 29) == 0) begin
                bus.attack = ($urandom_range(0, 7) == 0) ? 14'd0 : 14'($urandom_range(1, 16383));
                bus.decay  = ($urandom_range(0, 7) == 0) ? 14'd0 : 14'($urandom_range(1, 16383));
                bus.rel    = ($urandom_range(0, 7) == 0) ? 14'd0 : 14'($urandom_range(1, 16383));
                case ($urandom_range(0, 2))
                    0: bus.sustain = 32'($urandom);
                    1: bus.sustain = 32'hFFFF_0000 | 32'($urandom_range(0, 65535));
                    default: bus.sustain = 32'($urandom_range(0, 100000));
                endcase
            end
            rst_n = ($urandom_range(0, 499) != 0);
            clk_step();
            rst_n = 1'b1;
        end
        $display("test random traffic: done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
